mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single unified main memory between three requesters: I-cache miss fills, D-cache miss fills and D-cache write-through stores. Each fill is sequenced as a block of eight 16-bit words issued on consecutive cycles, and returned data is steered into the requesting cache's data array. The block sits between both caches and the multi-cycle memory model. It is the only block that drives the memory's address and enable lines.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS_PER_BLK, 8, words per cache block (power of two)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_miss  in  1  I-cache miss; level, held until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache miss byte address
- d_miss  in  1  D-cache miss; level, held until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache miss byte address
- st_req  in  1  store request; level, held until st_ack
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- st_ack  out  1  one-cycle store acknowledge
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_valid  in  1  mem_rdata valid, one cycle per issued read
- fill_data  out  DATA_W  returned word, equal to mem_rdata
- fill_word  out  3  word index within the block
- fill_wr_i  out  1  write fill_data into the I-cache
- fill_wr_d  out  1  write fill_data into the D-cache
- i_fill_done  out  1  one-cycle pulse, I fill complete
- d_fill_done  out  1  one-cycle pulse, D fill complete

## Operation
- FSM states: IDLE, WRITE, FILL, DONE.
- IDLE grant priority is fixed: st_req first, then d_miss, then i_miss.
  - Store granted → WRITE.
  - Either miss granted → FILL. On grant, latch the source, blk = addr[ADDR_W-1:4] and off = addr[3:1].
  - Requests are sampled only in IDLE.
- WRITE lasts one cycle.
  - Drives mem_en=1, mem_wr=1, mem_addr=st_addr, mem_wdata=st_data, st_ack=1.
  - Next state is IDLE.
- FILL uses two 4-bit counters, icnt (issue) and rcnt (return), both cleared on entry.
  - While icnt<8: mem_en=1, mem_wr=0, mem_addr={blk, (start+icnt) mod 8, 1'b0}, then icnt++.
  - Each mem_valid: fill_wr_{src}=1, fill_word=(start+rcnt) mod 8, then rcnt++.
  - Issue and return may overlap.
  - When rcnt reaches 8 → DONE.
- DONE lasts one cycle. It pulses {src}_fill_done, ignores all requests, and moves to IDLE.
  - A requester's miss/req must be low by the cycle after its done/ack. Requests sampled in IDLE are therefore always fresh.
- mem_valid outside FILL is ignored: no fill_wr, no counter change.
- Word index wraps modulo 8. Address bit 0 is forced 0.
- A store arriving during a fill waits until IDLE. There is no preemption.
- When none of the drive conditions above apply, every output is 0.

## Timing
- Async reset: state=IDLE, counters=0, all outputs 0 immediately, including mid-WRITE or mid-FILL.
  - An in-flight fill is abandoned. The requester re-requests after reset.
- Store: req sampled in IDLE at cycle N; write and st_ack at N+1; IDLE at N+2.
- Fill: miss sampled at N; issues at N+1..N+8.
  - With memory latency L, returns arrive at N+1+L..N+8+L.
  - DONE at N+9+L; IDLE at N+10+L.
- A back-to-back grant is possible from the IDLE cycle, so the next access starts at N+11+L.
- Outputs are combinational from state and counters. Latched addresses are registered.

## Configuration
- CRITICAL_WORD_FIRST_EN
  - Defined: start=off, so issue and fill_word begin at the missed word and wrap.
  - Undefined: start=0 and off is not latched.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, WRITE, FILL, DONE}
  - source enum {SRC_I, SRC_D}
  - WORDS_PER_BLK and OFFSET_W=3 constants
- One sub-module, fill_seq: icnt/rcnt counters and the modulo-8 word index generation. Inputs are start, clear, issue and valid. Outputs are word indices, issue_busy and last.

## Test plan
- Lone I fill, memory latency 4, CWF off, i_miss addr 0x1236 at cycle 0 →
  - mem_addr 0x1230..0x123E at cycles 1–8
  - fill_wr_i at cycles 5–12 with fill_word 0..7
  - i_fill_done at 13
- i_miss and d_miss asserted together at cycle 0 →
  - D fill first, d_fill_done at 13
  - I issue starts at cycle 15
  - fill_wr_i is never asserted during the D fill
- st_req (0x0040, 0xBEEF) and d_miss at cycle 0 →
  - mem_wr=1 with addr 0x0040 and st_ack at cycle 1
  - D fill issues from cycle 3
- CWF on, d_miss addr 0x123A →
  - issue order 0x123A, 0x123C, 0x123E, 0x1230 … 0x1238
  - fill_word 5, 6, 7, 0 … 4
- rst_n low at cycle 6 of an I fill →
  - all outputs 0 immediately
  - stray mem_valid at cycles 7–12 produce no fill_wr
  - a new i_miss after release fills normally from word 0
- st_req raised at cycle 3 during an I fill →
  - no mem_wr until after i_fill_done at 13
  - st_ack at cycle 15

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the main-memory arbiter.
//   state_e  : arbiter FSM states
//   src_e    : which cache owns the fill in progress
//   WORDS_PER_BLK / OFFSET_W / CNT_W : block geometry and counter width
//   wrap_idx : word index within a block, wrapping modulo WORDS_PER_BLK
package mem_arb_pkg;

    localparam int WORDS_PER_BLK = 8;
    localparam int OFFSET_W      = 3;
    // One extra bit so a counter can hold the terminal value WORDS_PER_BLK.
    localparam int CNT_W         = OFFSET_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL,
        DONE
    } state_e;

    typedef enum logic {
        SRC_I,
        SRC_D
    } src_e;

    function automatic logic [OFFSET_W-1:0] wrap_idx(input logic [OFFSET_W-1:0] start,
                                                     input logic [OFFSET_W-1:0] cnt);
        return start + cnt;
    endfunction

endpackage

// File: rtl/mem_arbiter_fill_seq.sv
// fill_seq: issue/return word sequencer for one block fill.
//   clk, rst_n     : clock, async active-low reset
//   start_i        : first word index of the block (critical word or 0)
//   clear_i        : restart both counters (fill grant)
//   issue_i        : a read may be issued this cycle
//   valid_i        : a read word returns this cycle
//   issue_word_o   : word index of the read being issued
//   ret_word_o     : word index of the word being returned
//   issue_busy_o   : reads remain to be issued
//   last_o         : the final word of the block returns this cycle
module fill_seq
    import mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OFFSET_W-1:0] start_i,
    input  logic                clear_i,
    input  logic                issue_i,
    input  logic                valid_i,
    output logic [OFFSET_W-1:0] issue_word_o,
    output logic [OFFSET_W-1:0] ret_word_o,
    output logic                issue_busy_o,
    output logic                last_o
);

    localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(WORDS_PER_BLK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_BLK - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    assign issue_busy_o = (icnt_q != BLK_CNT);
    assign last_o       = valid_i && (rcnt_q == LAST_CNT);
    assign issue_word_o = wrap_idx(start_i, icnt_q[OFFSET_W-1:0]);
    assign ret_word_o   = wrap_idx(start_i, rcnt_q[OFFSET_W-1:0]);

    always_comb begin
        icnt_d = icnt_q;
        rcnt_d = rcnt_q;
        if (clear_i) begin
            icnt_d = '0;
            rcnt_d = '0;
        end else begin
            if (issue_i && issue_busy_o) begin
                icnt_d = icnt_q + ONE;
            end
            // Saturate so a stray extra valid cannot wrap the return count.
            if (valid_i && (rcnt_q != BLK_CNT)) begin
                rcnt_d = rcnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
            rcnt_q <= rcnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole master of main memory, shared by I-cache fills,
// D-cache fills and D-cache write-through stores.
//   Requests : i_miss/i_miss_addr, d_miss/d_miss_addr, st_req/st_addr/st_data
//   Store ack: st_ack
//   Memory   : mem_en, mem_wr, mem_addr, mem_wdata, mem_rdata, mem_valid
//   Fill     : fill_data, fill_word, fill_wr_i, fill_wr_d, i_fill_done, d_fill_done
// Build option CRITICAL_WORD_FIRST_EN: when defined, a fill starts at the
// missed word and wraps; otherwise every fill starts at word 0.
//
// state | meaning
// IDLE  | sample requests; priority store > D miss > I miss
// WRITE | one-cycle memory write of the store, st_ack
// FILL  | issue block reads, steer returned words into the owning cache
// DONE  | one-cycle fill-done pulse, requests ignored
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_miss,
    input  logic [ADDR_W-1:0]   i_miss_addr,
    input  logic                d_miss,
    input  logic [ADDR_W-1:0]   d_miss_addr,
    input  logic                st_req,
    input  logic [ADDR_W-1:0]   st_addr,
    input  logic [DATA_W-1:0]   st_data,
    output logic                st_ack,
    output logic                mem_en,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_valid,
    output logic [DATA_W-1:0]   fill_data,
    output logic [OFFSET_W-1:0] fill_word,
    output logic                fill_wr_i,
    output logic                fill_wr_d,
    output logic                i_fill_done,
    output logic                d_fill_done
);

    localparam int BLK_W = ADDR_W - OFFSET_W - 1;

    state_e              state_q;
    src_e                src_q;
    logic [BLK_W-1:0]    blk_q;
    logic [OFFSET_W-1:0] start_w;

    logic                grant_st, grant_d, grant_i, grant_fill;
    logic [ADDR_W-1:0]   miss_addr;

    logic [OFFSET_W-1:0] issue_word, ret_word;
    logic                issue_busy, seq_last;

    assign grant_st   = (state_q == IDLE) && st_req;
    assign grant_d    = (state_q == IDLE) && !st_req && d_miss;
    assign grant_i    = (state_q == IDLE) && !st_req && !d_miss && i_miss;
    assign grant_fill = grant_d || grant_i;
    assign miss_addr  = grant_d ? d_miss_addr : i_miss_addr;

    // Byte-select bit is never used; the in-block offset only with critical word first.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{miss_addr[OFFSET_W:0], st_addr[0]};

`ifdef CRITICAL_WORD_FIRST_EN
    logic [OFFSET_W-1:0] off_q;
    assign start_w = off_q;
`else
    assign start_w = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= SRC_I;
            blk_q   <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            off_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_st) begin
                        state_q <= WRITE;
                    end else if (grant_fill) begin
                        state_q <= FILL;
                        src_q   <= grant_d ? SRC_D : SRC_I;
                        blk_q   <= miss_addr[ADDR_W-1:OFFSET_W+1];
`ifdef CRITICAL_WORD_FIRST_EN
                        off_q   <= miss_addr[OFFSET_W:1];
`endif
                    end
                end
                WRITE:   state_q <= IDLE;
                FILL:    if (seq_last) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Returns are only meaningful while filling; anything else is dropped here.
    fill_seq u_fill_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_w),
        .clear_i      (grant_fill),
        .issue_i      (state_q == FILL),
        .valid_i      ((state_q == FILL) && mem_valid),
        .issue_word_o (issue_word),
        .ret_word_o   (ret_word),
        .issue_busy_o (issue_busy),
        .last_o       (seq_last)
    );

    always_comb begin
        st_ack      = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_word   = '0;
        fill_wr_i   = 1'b0;
        fill_wr_d   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        case (state_q)
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {st_addr[ADDR_W-1:1], 1'b0};
                mem_wdata = st_data;
                st_ack    = 1'b1;
            end
            FILL: begin
                if (issue_busy) begin
                    mem_en   = 1'b1;
                    mem_addr = {blk_q, issue_word, 1'b0};
                end
                if (mem_valid) begin
                    fill_data = mem_rdata;
                    fill_word = ret_word;
                    fill_wr_i = (src_q == SRC_I);
                    fill_wr_d = (src_q == SRC_D);
                end
            end
            DONE: begin
                i_fill_done = (src_q == SRC_I);
                d_fill_done = (src_q == SRC_D);
            end
            default: ;
        endcase
    end

endmodule
